// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite word-organised SRAM responder with byte/half/word writes and two-cycle ERROR.
// Optional data-phase wait states are compiled in with `define AHB_SRAM_WAIT_EN.
`timescale 1ns/1ps

module ahb_lite_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH   = 2 ** WORD_AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            size;
    logic                  write;
  } aphase_t;

  state_t        state_q, state_nxt;
  aphase_t       aph_q;
  logic [31:0]   mem [DEPTH];

  logic          accept_c;
  logic          legal_c;
  logic          take_c;
  logic          commit_c;
  logic [3:0]    be_c;
  logic [31:0]   merged_c;
  logic [31:0]   rd_word_c;
  logic [WORD_AW-1:0] wr_idx_c;
  logic [WORD_AW-1:0] rd_idx_c;
  logic          ready_nxt;
  logic          resp_nxt;
  logic [31:0]   rdata_nxt;
  logic          wait_done_nxt;

  // Address-phase qualification and transfer legality
  always_comb begin
    accept_c = HSEL & HREADY & HTRANS[1];
    legal_c  = 1'b1;
    if (HSIZE > 3'd2)                              legal_c = 1'b0;
    else if (HSIZE == 3'd1 && HADDR[0])            legal_c = 1'b0;
    else if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) legal_c = 1'b0;
    take_c = accept_c & (state_q != ST_ERR1) & ~((state_q == ST_DATA) & ~HREADYOUT);
  end

`ifdef AHB_SRAM_WAIT_EN
  localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_nxt;

  // Legal transfers reload the stretch counter; it drains one per cycle in DATA
  always_comb begin
    wait_cnt_nxt = wait_cnt_q;
    if (take_c && legal_c)
      wait_cnt_nxt = CNT_W'(WAIT_STATES);
    else if (state_q == ST_DATA && wait_cnt_q != '0)
      wait_cnt_nxt = wait_cnt_q - CNT_W'(1);
    wait_done_nxt = (wait_cnt_nxt == '0);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_nxt;
  end

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH], HTRANS[0]};
`else
  always_comb wait_done_nxt = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH], HTRANS[0], 32'(WAIT_STATES)};
`endif

  // State register
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (take_c) state_nxt = legal_c ? ST_DATA : ST_ERR1;
        else        state_nxt = ST_IDLE;
      end
      ST_DATA: begin
        if (HREADYOUT) begin
          if (take_c) state_nxt = legal_c ? ST_DATA : ST_ERR1;
          else        state_nxt = ST_IDLE;
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Byte-lane merge of the write data into the addressed word
  always_comb begin
    wr_idx_c = aph_q.addr[ADDR_WIDTH-1:2];
    rd_idx_c = HADDR[ADDR_WIDTH-1:2];
    case (aph_q.size)
      3'd0:    be_c = 4'b0001 << aph_q.addr[1:0];
      3'd1:    be_c = aph_q.addr[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
    for (int i = 0; i < 4; i++)
      merged_c[8*i +: 8] = be_c[i] ? HWDATA[8*i +: 8] : mem[wr_idx_c][8*i +: 8];
    commit_c  = (state_q == ST_DATA) & HREADYOUT & aph_q.write & ~HRESET;
    rd_word_c = (commit_c && rd_idx_c == wr_idx_c) ? merged_c : mem[rd_idx_c];
  end

  // Output values for the cycle after this edge
  always_comb begin
    ready_nxt = 1'b1;
    resp_nxt  = 1'b0;
    rdata_nxt = 32'h0;
    case (state_nxt)
      ST_DATA: ready_nxt = wait_done_nxt;
      ST_ERR1: begin ready_nxt = 1'b0; resp_nxt = 1'b1; end
      ST_ERR2: resp_nxt = 1'b1;
      default: ready_nxt = 1'b1;
    endcase
    if (take_c && legal_c && !HWRITE)
      rdata_nxt = rd_word_c;
    else if (state_q == ST_DATA && !HREADYOUT)
      rdata_nxt = HRDATA;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= 32'h0;
      aph_q     <= '0;
    end else begin
      HREADYOUT <= ready_nxt;
      HRESP     <= resp_nxt;
      HRDATA    <= rdata_nxt;
      if (take_c)
        aph_q <= '{addr: HADDR[ADDR_WIDTH-1:0], size: HSIZE, write: HWRITE};
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge HCLK) begin
    if (commit_c) mem[wr_idx_c] <= merged_c;
  end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Scoreboard bench for ahb_lite_sram_slave: byte-array reference model, randomized AHB traffic.
`timescale 1ns/1ps

module tb_ahb_lite_sram_slave;

  localparam int unsigned AW = 12;
  localparam int unsigned WS = 2;
`ifdef AHB_SRAM_WAIT_EN
  localparam int EXP_WAIT = WS;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  assign HREADY = HREADYOUT;

  ahb_lite_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mem_m [4096];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         mon_active = 1'b0;
  int         mon_waits  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input int addr);
    int w;
    w = addr & 32'hFFC;
    return {mem_m[w+3], mem_m[w+2], mem_m[w+1], mem_m[w]};
  endfunction

  // Predict the response, update the model, then drive the address phase until accepted
  task automatic issue(input logic [31:0] addr, input logic [2:0] size, input logic wr,
                       input logic [31:0] wdata, input bit use_k = 1'b0,
                       input logic [31:0] k = 32'h0);
    int   a;
    bit   illegal;
    bit   rdy;
    int   guard;
    exp_t e;
    a = int'(addr[AW-1:0]);
    illegal = (size > 3'd2) || (size == 3'd1 && (a % 2) != 0) || (size == 3'd2 && (a % 4) != 0);
    e.err   = illegal;
    e.waits = illegal ? 1 : EXP_WAIT;
    e.rdata = 32'h0;
    if (!illegal) begin
      if (wr) begin
        for (int i = 0; i < (1 << size); i++)
          mem_m[a+i] = wdata[8*((a%4)+i) +: 8];
      end else begin
        e.rdata = use_k ? k : model_word(a);
      end
    end
    sb_q.push_back(e);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HSIZE = size; HWRITE = wr;
    guard = 0;
    do begin
      @(negedge HCLK); rdy = HREADYOUT;
      @(posedge HCLK); #1;
      guard++;
    end while (!rdy && guard < 50);
    if (!rdy) check("accept_timeout", 32'(rdy), 32'h1);
    HWDATA = wr ? wdata : $urandom;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic gap(input int n, input int kind);
    for (int i = 0; i < n; i++) begin
      case (kind)
        1:       begin HSEL = 1'b1; HTRANS = 2'b01; HADDR = $urandom; end
        2:       begin HSEL = 1'b0; HTRANS = 2'b10; HADDR = $urandom; HWRITE = 1'b1; end
        default: begin HSEL = 1'b0; HTRANS = 2'b00; end
      endcase
      @(posedge HCLK); #1;
    end
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  // Monitor: tracks data phases from the bus and compares on completion
  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        mon_active = 1'b0;
        mon_waits  = 0;
      end else begin
        if (mon_active) begin
          if (sb_q.size() == 0) begin
            check("unexpected_data_phase", 32'(sb_q.size()), 32'h1);
            mon_active = 1'b0;
          end else if (!HREADYOUT) begin
            mon_waits++;
            check("wait_hresp", 32'(HRESP), 32'(sb_q[0].err));
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("hresp", 32'(HRESP), 32'(e.err));
            check("hrdata", HRDATA, e.rdata);
            check("wait_cycles", 32'(mon_waits), 32'(e.waits));
            mon_active = 1'b0;
          end
        end
        if (HSEL && HREADYOUT && HTRANS[1]) begin
          mon_active = 1'b1;
          mon_waits  = 0;
        end
      end
    end
  end

  initial begin
    logic [31:0] upper;
    logic [31:0] old_word;
    int          guard;
    HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd0; HWDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    #1;
    check("reset_hreadyout", 32'(HREADYOUT), 32'h1);
    check("reset_hresp", 32'(HRESP), 32'h0);
    check("reset_hrdata", HRDATA, 32'h0);
    #2 HRESET = 1'b0;
    @(posedge HCLK); #1;

    for (int w = 0; w < 64; w++) issue(32'(w * 4), 3'd2, 1'b1, $urandom);

    issue(32'h010, 3'd2, 1'b1, 32'hDEADBEEF);
    issue(32'h010, 3'd2, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
    gap(2, 0);
    issue(32'h013, 3'd0, 1'b1, 32'hA5000000);
    issue(32'h010, 3'd2, 1'b0, 32'h0, 1'b1, 32'hA5ADBEEF);
    gap(1, 0);
    issue(32'h011, 3'd1, 1'b1, 32'h77665544);
    issue(32'h010, 3'd2, 1'b0, 32'h0, 1'b1, 32'hA5ADBEEF);
    issue(32'h020, 3'd2, 1'b1, 32'h12345678);
    issue(32'h020, 3'd2, 1'b0, 32'h0, 1'b1, 32'h12345678);
    issue(32'h1010, 3'd2, 1'b0, 32'h0, 1'b1, 32'hA5ADBEEF);
    gap(2, 1);

    for (int n = 0; n < 300; n++) begin
      logic [2:0] sz;
      sz    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      upper = $urandom & 32'hFFFF_F000;
      issue(upper | 32'($urandom_range(0, 255)), sz, 1'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2), $urandom_range(0, 2));
    end
    gap(6, 0);

    // Reset during the data phase of a word write must abort the commit
    old_word = model_word(32'h040);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h040; HSIZE = 3'd2; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    HWDATA = 32'hCAFEF00D; HSEL = 1'b0; HTRANS = 2'b00;
    #1 HRESET = 1'b1;
    #1;
    check("abort_hreadyout", 32'(HREADYOUT), 32'h1);
    check("abort_hresp", 32'(HRESP), 32'h0);
    @(posedge HCLK); #2 HRESET = 1'b0;
    @(posedge HCLK); #1;
    issue(32'h040, 3'd2, 1'b0, 32'h0, 1'b1, old_word);
    issue(32'h044, 3'd2, 1'b1, 32'h0BADF00D);
    issue(32'h044, 3'd2, 1'b0, 32'h0, 1'b1, 32'h0BADF00D);

    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(posedge HCLK); #1;
      guard++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
